// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: mode encodings, mode state type
// and a counter-width helper.
package clock_pkg;

  localparam logic [1:0] MODE_NORMAL   = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;

  typedef enum logic [1:0] {
    ST_NORMAL   = MODE_NORMAL,
    ST_SET_HOUR = MODE_SET_HOUR,
    ST_SET_MIN  = MODE_SET_MIN
  } mode_e;

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One front-panel key: 2-FF synchronizer, sample-tick debouncer and a
// one-cycle press event (released -> pressed) gated until the key is seen released.
module key_debounce
  import clock_pkg::*;
#(
  parameter int unsigned DEB_SAMPLES = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEB_SAMPLES);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;
  logic             sample_c;

  assign sample_c = ~sync_q[1];

  // After reset a key that is still held must be sampled released before it may fire.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      press  <= 1'b0;
      if (tick) begin
        if (sample_c != level) begin
          if (cnt_q == CNT_W'(DEB_SAMPLES - 1)) begin
            level <= sample_c;
            cnt_q <= '0;
            press <= sample_c & armed_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_q <= '0;
          if (!sample_c) armed_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: NORMAL / SET_HOUR / SET_MIN mode machine
// driving hour/minute INC pulses, SEC_CLR and RUN. Auto-repeat built when AUTO_REPEAT_EN is defined.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = 50000,
  parameter int unsigned DEB_SAMPLES  = 8,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_MODE_N,
  input  logic       KEY_INC_N,
  output logic [1:0] MODE,
  output logic       RUN,
  output logic       INC_HOUR,
  output logic       INC_MIN,
  output logic       SEC_CLR
);

  localparam int unsigned DIV_W = cnt_width(SAMPLE_DIV);

  logic [DIV_W-1:0] div_q;
  logic             tick_c;
  logic             mode_press, inc_press, inc_level, mode_level_unused;
  logic             rep_fire_c;
  mode_e            state_q, state_d;
  logic             inc_hour_d, inc_min_d, sec_clr_d;

  // Free-running debounce sample divider.
  assign tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         div_q <= '0;
    else if (tick_c) div_q <= '0;
    else             div_q <= div_q + DIV_W'(1);
  end

  key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_mode_deb (
    .CLK   (CLK),
    .RST   (RST),
    .tick  (tick_c),
    .key_n (KEY_MODE_N),
    .level (mode_level_unused),
    .press (mode_press)
  );

  key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_inc_deb (
    .CLK   (CLK),
    .RST   (RST),
    .tick  (tick_c),
    .key_n (KEY_INC_N),
    .level (inc_level),
    .press (inc_press)
  );

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = cnt_width(REP_MAX);

  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_phase_q, rep_active_q, rep_hit_c;

  assign rep_hit_c  = (rep_cnt_q == (rep_phase_q ? REP_W'(REPEAT_RATE - 1)
                                                 : REP_W'(REPEAT_DELAY - 1)));
  assign rep_fire_c = tick_c & rep_active_q & inc_level & rep_hit_c;

  // Only an accepted INC press arms repeat, so a press lost to MODE never repeats.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rep_cnt_q    <= '0;
      rep_phase_q  <= 1'b0;
      rep_active_q <= 1'b0;
    end else if (mode_press || !inc_level) begin
      rep_cnt_q    <= '0;
      rep_phase_q  <= 1'b0;
      rep_active_q <= 1'b0;
    end else if (inc_press && (state_q != ST_NORMAL)) begin
      rep_cnt_q    <= '0;
      rep_phase_q  <= 1'b0;
      rep_active_q <= 1'b1;
    end else if (tick_c && rep_active_q) begin
      if (rep_hit_c) begin
        rep_cnt_q   <= '0;
        rep_phase_q <= 1'b1;
      end else begin
        rep_cnt_q <= rep_cnt_q + REP_W'(1);
      end
    end
  end
`else
  logic unused_rep;
  assign rep_fire_c = 1'b0;
  assign unused_rep = ^{inc_level, REPEAT_DELAY, REPEAT_RATE};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_NORMAL;
      RUN      <= 1'b1;
      INC_HOUR <= 1'b0;
      INC_MIN  <= 1'b0;
      SEC_CLR  <= 1'b0;
    end else begin
      state_q  <= state_d;
      RUN      <= (state_d == ST_NORMAL);
      INC_HOUR <= inc_hour_d;
      INC_MIN  <= inc_min_d;
      SEC_CLR  <= sec_clr_d;
    end
  end

  // MODE press has priority over any INC activity in the same cycle.
  always_comb begin
    state_d    = state_q;
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    sec_clr_d  = 1'b0;
    if (mode_press) begin
      case (state_q)
        ST_NORMAL:   state_d = ST_SET_HOUR;
        ST_SET_HOUR: state_d = ST_SET_MIN;
        ST_SET_MIN: begin
          state_d   = ST_NORMAL;
          sec_clr_d = 1'b1;
        end
        default:     state_d = ST_NORMAL;
      endcase
    end else if (inc_press || rep_fire_c) begin
      if (state_q == ST_SET_HOUR)     inc_hour_d = 1'b1;
      else if (state_q == ST_SET_MIN) inc_min_d  = 1'b1;
    end
  end

  assign MODE = state_q;

endmodule
